// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: fetch PC, in-order request tracking, prefetch FIFO and registered IFPC/INS output.
// Optional macro IF_ALIGN_CHECK_EN: misaligned redirect targets raise sticky IFMisalign and halt fetch.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    output logic [31:0] IFPC,
    output logic [31:0] INS,
    output logic        IFValid,
    output logic        IFMisalign
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW-1:0] ard_q, ard_d, awr_q, awr_d;
    logic [CW-1:0] cnt_q, cnt_d, osd_q, osd_d, dsc_q, dsc_d;
    logic [31:0]   ifpc_q, ifpc_d, ins_q, ins_d;
    logic          ifv_q, ifv_d, mis_q, mis_d;

    logic [31:0]   fd_q [DEPTH];
    logic [31:0]   fp_q [DEPTH];
    logic [31:0]   ap_q [DEPTH];

    logic          req_c, gnt, resp, keep, enq, pop, halted, redir_mis;
    logic [31:0]   redir_pc, resp_pc;

`ifdef IF_ALIGN_CHECK_EN
    assign redir_pc  = RedirectPC;
    assign redir_mis = (RedirectPC[1:0] != 2'b00);
    assign halted    = mis_q;
`else
    assign redir_pc  = RedirectPC & 32'hFFFF_FFFC;
    assign redir_mis = 1'b0;
    assign halted    = 1'b0;
`endif

    // Occupancy of buffered plus in-flight words bounds new requests, so the FIFO never overflows.
    assign req_c   = rst_n && ((SW'(cnt_q) + SW'(osd_q)) < SW'(DEPTH)) && !Redirect && !halted;
    assign gnt     = req_c && IMemGnt;
    assign resp    = IMemRValid && (osd_q != '0);
    assign keep    = resp && (dsc_q == '0);
    assign resp_pc = ap_q[ard_q];

    assign IMemReq    = req_c;
    assign IMemAddr   = pc_q;
    assign IFPC       = ifpc_q;
    assign INS        = ins_q;
    assign IFValid    = ifv_q;
    assign IFMisalign = mis_q;

    // Next-state logic for fetch PC, request tracking, prefetch FIFO and output register.
    always_comb begin
        pc_d   = pc_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        ard_d  = ard_q;
        awr_d  = awr_q;
        cnt_d  = cnt_q;
        osd_d  = osd_q;
        dsc_d  = dsc_q;
        ifpc_d = ifpc_q;
        ins_d  = ins_q;
        ifv_d  = ifv_q;
        mis_d  = mis_q;
        enq    = 1'b0;
        pop    = 1'b0;

        if (gnt) begin
            pc_d  = pc_q + 32'd4;
            awr_d = awr_q + PW'(1);
        end
        if (resp) begin
            ard_d = ard_q + PW'(1);
        end
        osd_d = osd_q + CW'(gnt) - CW'(resp);
        if (resp && !keep) begin
            dsc_d = dsc_q - CW'(1);
        end

        if (Redirect) begin
            // Every word still in flight after this cycle belongs to the flushed stream.
            pc_d  = redir_pc;
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            ins_d = NOP;
            ifv_d = 1'b0;
            dsc_d = osd_q - CW'(resp);
            mis_d = redir_mis;
        end else begin
            if (!Stall) begin
                if (cnt_q != '0) begin
                    pop    = 1'b1;
                    ifpc_d = fp_q[rd_q];
                    ins_d  = fd_q[rd_q];
                    ifv_d  = 1'b1;
                end else if (keep) begin
                    ifpc_d = resp_pc;
                    ins_d  = IMemRData;
                    ifv_d  = 1'b1;
                end else begin
                    ins_d = NOP;
                    ifv_d = 1'b0;
                end
            end
            enq = keep && (Stall || (cnt_q != '0));
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            if (enq) begin
                wr_d = wr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(enq) - CW'(pop);
        end
    end

    // Control and output state.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            rd_q   <= '0;
            wr_q   <= '0;
            ard_q  <= '0;
            awr_q  <= '0;
            cnt_q  <= '0;
            osd_q  <= '0;
            dsc_q  <= '0;
            ifpc_q <= 32'h0;
            ins_q  <= NOP;
            ifv_q  <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            ard_q  <= ard_d;
            awr_q  <= awr_d;
            cnt_q  <= cnt_d;
            osd_q  <= osd_d;
            dsc_q  <= dsc_d;
            ifpc_q <= ifpc_d;
            ins_q  <= ins_d;
            ifv_q  <= ifv_d;
            mis_q  <= mis_d;
        end
    end

    // Storage arrays; contents are only read when the matching count marks them valid.
    always_ff @(posedge CLK) begin
        if (enq) begin
            fd_q[wr_q] <= IMemRData;
            fp_q[wr_q] <= resp_pc;
        end
        if (gnt) begin
            ap_q[awr_q] <= pc_q;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand sequences for flush/wrap/reset corners,
// and randomized memory/stall/redirect traffic checked against a queue-based reference model.
module tb_if_fetch_unit;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        rst_n, Stall, Redirect, IMemGnt, IMemRValid;
    logic [31:0] RedirectPC, IMemRData;
    logic        IMemReq, IFValid, IFMisalign;
    logic [31:0] IMemAddr, IFPC, INS;

    int n_cmp = 0;
    int n_bad = 0;
    int cycn  = 0;

    always #5 CLK = ~CLK;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .rst_n(rst_n), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt), .IMemRValid(IMemRValid),
        .IMemRData(IMemRData), .IFPC(IFPC), .INS(INS), .IFValid(IFValid), .IFMisalign(IFMisalign)
    );

    typedef struct packed { logic [31:0] pc; logic disc; } ot_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] data; } wd_t;
    typedef struct packed { logic [31:0] a; logic [31:0] rdy; } mr_t;
    typedef struct packed {
        logic st; logic rd; logic [31:0] rpc; logic gn; logic rv; logic [31:0] rda;
        logic e_req; logic [31:0] e_addr; logic e_v; logic [31:0] e_pc;
    } vec_t;

    ot_t oq[$];
    wd_t bq[$];
    mr_t memq[$];
    logic [31:0] m_pc, m_ifpc, m_ins;
    logic        m_v, m_mis;
    vec_t        tbl [14];

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cycn, act, exp);
        end
    endtask

    task automatic mreset();
        oq.delete();
        bq.delete();
        m_pc   = 32'h0;
        m_ifpc = 32'h0;
        m_ins  = NOP;
        m_v    = 1'b0;
        m_mis  = 1'b0;
    endtask

    function automatic logic m_req();
        return rst_n && ((bq.size() + oq.size()) < int'(DEPTH)) && !Redirect && !m_mis;
    endfunction

    task automatic model_check();
        int nd;
        nd = 0;
        foreach (oq[i]) if (oq[i].disc) nd++;
        chk("IMemReq", 32'(IMemReq), 32'(m_req()));
        chk("IMemAddr", IMemAddr, m_pc);
        chk("IFPC", IFPC, m_ifpc);
        chk("INS", INS, m_ins);
        chk("IFValid", 32'(IFValid), 32'(m_v));
        chk("IFMisalign", 32'(IFMisalign), 32'(m_mis));
        chk("outstanding", 32'(dut.osd_q), 32'(oq.size()));
        chk("discard", 32'(dut.dsc_q), 32'(nd));
        chk("fifo_count", 32'(dut.cnt_q), 32'(bq.size()));
        n_cmp++;
        if ((32'(dut.cnt_q) + 32'(dut.osd_q)) > DEPTH) begin
            n_bad++;
            $display("FAIL occupancy @cyc %0d: got %0d allowed %0d", cycn,
                     32'(dut.cnt_q) + 32'(dut.osd_q), DEPTH);
        end
    endtask

    task automatic model_step();
        ot_t  e;
        wd_t  w, h;
        logic keep, g;
        keep = 1'b0;
        w    = '0;
        g    = m_req() && IMemGnt;
        if (IMemRValid && oq.size() > 0) begin
            e = oq.pop_front();
            if (!e.disc) begin
                keep = 1'b1;
                w    = '{pc: e.pc, data: IMemRData};
            end
        end
        if (g) begin
            oq.push_back('{pc: m_pc, disc: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (Redirect) begin
            foreach (oq[i]) oq[i].disc = 1'b1;
            bq.delete();
            m_ins = NOP;
            m_v   = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            m_pc  = RedirectPC;
            m_mis = (RedirectPC % 4) != 0;
`else
            m_pc  = RedirectPC - (RedirectPC % 4);
`endif
        end else if (!Stall) begin
            if (bq.size() > 0) begin
                h      = bq.pop_front();
                m_ifpc = h.pc;
                m_ins  = h.data;
                m_v    = 1'b1;
                if (keep) bq.push_back(w);
            end else if (keep) begin
                m_ifpc = w.pc;
                m_ins  = w.data;
                m_v    = 1'b1;
            end else begin
                m_ins = NOP;
                m_v   = 1'b0;
            end
        end else if (keep) begin
            bq.push_back(w);
        end
    endtask

    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic gn, input logic rv, input logic [31:0] rdat);
        @(negedge CLK);
        Stall      = st;
        Redirect   = rd;
        RedirectPC = rpc;
        IMemGnt    = gn;
        IMemRValid = rv;
        IMemRData  = rdat;
        #1;
        model_check();
        if (rst_n) model_step();
        else mreset();
        cycn++;
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        rst_n = 1'b0;
        memq.delete();
        mreset();
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("rst_IMemReq", 32'(IMemReq), 32'h0);
            chk("rst_IFPC", IFPC, 32'h0);
            chk("rst_INS", INS, NOP);
            chk("rst_IFValid", 32'(IFValid), 32'h0);
            chk("rst_IFMisalign", 32'(IFMisalign), 32'h0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic        st, rd, gn, rv;
        logic [31:0] rpc, rdat;

        rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
        IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = 32'h0;

        // st rd rpc gn rv rda | e_req e_addr e_v e_pc ; one-cycle memory, stall, redirect+stall+response
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h8,   1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'hC,   1'b1, 32'h4};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b0, 32'h10,  1'b1, 32'h4};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h4};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h4};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h14,  1'b1, 32'hC};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  1'b1, 32'h18,  1'b1, 32'h10};
        tbl[10] = '{1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h18,  1'b0, 32'h1C,  1'b1, 32'h14};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h14};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b1, 32'h104, 1'b0, 32'h14};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b1, 32'h108, 1'b1, 32'h100};

        do_reset(3);

        for (int k = 0; k < 14; k++) begin
            cyc(tbl[k].st, tbl[k].rd, tbl[k].rpc, tbl[k].gn, tbl[k].rv, dat(tbl[k].rda));
            chk($sformatf("tbl%0d_IMemReq", k), 32'(IMemReq), 32'(tbl[k].e_req));
            chk($sformatf("tbl%0d_IMemAddr", k), IMemAddr, tbl[k].e_addr);
            chk($sformatf("tbl%0d_IFValid", k), 32'(IFValid), 32'(tbl[k].e_v));
            chk($sformatf("tbl%0d_IFPC", k), IFPC, tbl[k].e_pc);
            chk($sformatf("tbl%0d_INS", k), INS, tbl[k].e_v ? dat(tbl[k].e_pc) : NOP);
        end

        // Redirect with two requests in flight: both returning words are dropped.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("r2_addr0", IMemAddr, 32'h108);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("r2_addr1", IMemAddr, 32'h10C);
        cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
        chk("r2_noreq", 32'(IMemReq), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, dat(32'h108));
        chk("r2_full", 32'(IMemReq), 32'h0);
        chk("r2_bubble0", 32'(IFValid), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, dat(32'h10C));
        chk("r2_newaddr", IMemAddr, 32'h100);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, dat(32'h100));
        chk("r2_bubble1", 32'(IFValid), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("r2_valid", 32'(IFValid), 32'h1);
        chk("r2_pc", IFPC, 32'h100);
        chk("r2_ins", INS, dat(32'h100));

        // Fetch PC wraps from the top of the address space.
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr_top", IMemAddr, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, dat(32'hFFFF_FFFC));
        chk("wrap_addr_zero", IMemAddr, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc", IFPC, 32'hFFFF_FFFC);

`ifdef IF_ALIGN_CHECK_EN
        cyc(1'b0, 1'b1, 32'h102, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("mis_set", 32'(IFMisalign), 32'h1);
        chk("mis_halt0", 32'(IMemReq), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("mis_halt1", 32'(IMemReq), 32'h0);
        cyc(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        chk("mis_sticky", 32'(IFMisalign), 32'h1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("mis_clear", 32'(IFMisalign), 32'h0);
        chk("mis_resume_req", 32'(IMemReq), 32'h1);
        chk("mis_resume_addr", IMemAddr, 32'h200);
`else
        cyc(1'b0, 1'b1, 32'h102, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("mask_addr", IMemAddr, 32'h100);
        chk("mask_flag", 32'(IFMisalign), 32'h0);
`endif

        // Reset with requests in flight; a stale response afterwards must be ignored.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        do_reset(2);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("stale_valid", 32'(IFValid), 32'h0);
        chk("stale_ins", INS, NOP);

        // Randomized traffic: variable grant/response latency, stalls and redirects.
        for (int n = 0; n < 2500; n++) begin
            st  = ($urandom_range(0, 99) < 20);
            rd  = ($urandom_range(0, 99) < 4);
            gn  = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else rpc = $urandom & 32'h0000_0FFF;
`ifdef IF_ALIGN_CHECK_EN
            if ($urandom_range(0, 4) != 0) rpc = rpc & 32'hFFFF_FFFC;
`endif
            rv   = 1'b0;
            rdat = $urandom;
            if (memq.size() > 0) begin
                if (memq[0].rdy <= 32'(cycn) && $urandom_range(0, 99) < 80) begin
                    rv   = 1'b1;
                    rdat = dat(memq[0].a);
                    void'(memq.pop_front());
                end
            end else if ($urandom_range(0, 99) < 5) begin
                rv = 1'b1;
            end
            cyc(st, rd, rpc, gn, rv, rdat);
            if (IMemReq && IMemGnt)
                memq.push_back('{a: IMemAddr, rdy: 32'(cycn) + 32'($urandom_range(0, 2))});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
